// File: rtl/fetch_ctrl.sv
// F-stage fetch sequencer: owns the PC, arbitrates sequential/branch/CP0 redirects,
// flags fetch address errors (AdEL) and presents word, PC and exception code to F/D.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
   parameter logic [31:0] TEXT_END  = 32'h0000_3FFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_req,
   input  logic [31:0] br_pc,
   input  logic        exc_req,
   input  logic [31:0] exc_pc,
   output logic [11:0] im_addr,
   input  logic [31:0] im_instr,
   output logic [31:0] pc_f,
   output logic [31:0] instr_f,
   output logic [4:0]  exc_code_f,
   output logic        valid_f,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [4:0] EXC_ADEL = 5'd4;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] pend_pc_q;
   logic        pend_v_q;
   logic        valid_q;
   logic [31:0] cnt_q;

   logic [31:0] pc_seq_d;
   logic [31:0] cnt_d;
   logic        fetch_acc;
   logic        adel;

   assign pc_seq_d  = pc_q + 32'd4;
   assign cnt_d     = cnt_q + 32'd1;
   assign fetch_acc = valid_q & ~stall & ~exc_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         pend_pc_q <= 32'd0;
         pend_v_q  <= 1'b0;
         valid_q   <= 1'b0;
         cnt_q     <= 32'd0;
      end else begin
         if (fetch_acc) begin
            cnt_q <= cnt_d;
         end
         case (state_q)
            BOOT: begin
               state_q <= RUN;
               valid_q <= 1'b1;
            end
            RUN: begin
               if (exc_req) begin
                  pc_q <= exc_pc;
               end else if (br_req && !stall) begin
                  pc_q <= br_pc;
               end else if (br_req) begin
                  // Redirect arrives while F is frozen: park it until the stall clears.
                  pend_pc_q <= br_pc;
                  pend_v_q  <= 1'b1;
                  state_q   <= HOLD;
               end else if (!stall) begin
                  pc_q <= pc_seq_d;
               end
            end
            HOLD: begin
               if (exc_req) begin
                  pc_q     <= exc_pc;
                  pend_v_q <= 1'b0;
                  state_q  <= RUN;
               end else if (!stall) begin
                  if (pend_v_q) begin
                     pc_q <= pend_pc_q;
                  end
                  pend_v_q <= 1'b0;
                  state_q  <= RUN;
               end
            end
            default: begin
               state_q  <= BOOT;
               valid_q  <= 1'b0;
               pend_v_q <= 1'b0;
            end
         endcase
      end
   end

   assign adel = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_BASE) || (pc_q > TEXT_END);

   assign im_addr    = pc_q[13:2];
   assign pc_f       = pc_q;
   assign valid_f    = valid_q;
   assign exc_code_f = (valid_q && adel) ? EXC_ADEL : 5'd0;
   assign instr_f    = (valid_q && !adel) ? im_instr : 32'd0;
   assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a PC/pending-target model.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        br_req;
   logic [31:0] br_pc;
   logic        exc_req;
   logic [31:0] exc_pc;
   logic [11:0] im_addr;
   logic [31:0] im_instr;
   logic [31:0] pc_f;
   logic [31:0] instr_f;
   logic [4:0]  exc_code_f;
   logic        valid_f;
   logic [31:0] fetch_cnt;

   logic [31:0] mem [0:4095];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: fetch PC, whether boot cycle is over, queue of parked redirect targets.
   logic [31:0] m_pc;
   bit          m_booted;
   logic [31:0] m_pend[$];
   logic [31:0] m_cnt;

   fetch_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .br_req     (br_req),
      .br_pc      (br_pc),
      .exc_req    (exc_req),
      .exc_pc     (exc_pc),
      .im_addr    (im_addr),
      .im_instr   (im_instr),
      .pc_f       (pc_f),
      .instr_f    (instr_f),
      .exc_code_f (exc_code_f),
      .valid_f    (valid_f),
      .fetch_cnt  (fetch_cnt)
   );

   always #5 clk = ~clk;

   assign im_instr = mem[im_addr];

   function automatic bit m_adel();
      return (m_pc[1:0] != 2'b00) || (m_pc < 32'h3000) || (m_pc > 32'h3FFF);
   endfunction

   function automatic logic [31:0] m_instr();
      logic [11:0] idx;
      idx = m_pc[13:2];
      return (m_booted && !m_adel()) ? mem[idx] : 32'd0;
   endfunction

   function automatic logic [4:0] m_exc();
      return (m_booted && m_adel()) ? 5'd4 : 5'd0;
   endfunction

   function automatic logic [31:0] rand_pc();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) return 32'h3000 + $urandom_range(0, 4095);
      if (sel == 1) return $urandom();
      return 32'h3000 + ($urandom_range(0, 1023) << 2);
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         m_pc     = 32'h3000;
         m_booted = 1'b0;
         m_pend.delete();
         m_cnt    = 32'd0;
      end else if (!m_booted) begin
         m_booted = 1'b1;
      end else begin
         if (!stall && !exc_req) m_cnt = m_cnt + 32'd1;
         if (m_pend.size() != 0) begin
            if (exc_req) begin
               m_pc = exc_pc;
               m_pend.delete();
            end else if (!stall) begin
               m_pc = m_pend.pop_front();
            end
         end else begin
            if (exc_req) m_pc = exc_pc;
            else if (br_req && !stall) m_pc = br_pc;
            else if (br_req) m_pend.push_back(br_pc);
            else if (!stall) m_pc = m_pc + 32'd4;
         end
      end
      #1;
   endtask

   task automatic clear_inputs();
      stall   = 1'b0;
      br_req  = 1'b0;
      br_pc   = 32'd0;
      exc_req = 1'b0;
      exc_pc  = 32'd0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      exc_req = 1'b1;
      exc_pc  = 32'h3180;
      tick();
      exc_req = 1'b0;
      n_checks++; if (valid_f !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_f); else n_pass++;
      n_checks++; if (pc_f !== 32'h3000) $display("FAIL reset_pc: got %h want 00003000", pc_f); else n_pass++;
      n_checks++; if (instr_f !== 32'd0) $display("FAIL reset_instr: got %h want 0", instr_f); else n_pass++;
      n_checks++; if (exc_code_f !== 5'd0) $display("FAIL reset_exc: got %0d want 0", exc_code_f); else n_pass++;
      n_checks++; if (fetch_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_free_run();
      logic [11:0] idx;
      for (int i = 0; i < 3; i++) begin
         tick();
         idx = 12'hC00 + 12'(i);
         n_checks++; if (pc_f !== 32'h3000 + 32'(4 * i)) $display("FAIL run_pc%0d: got %h want %h", i, pc_f, 32'h3000 + 32'(4 * i)); else n_pass++;
         n_checks++; if (valid_f !== 1'b1) $display("FAIL run_valid%0d: got %b want 1", i, valid_f); else n_pass++;
         n_checks++; if (instr_f !== mem[idx]) $display("FAIL run_instr%0d: got %h want %h", i, instr_f, mem[idx]); else n_pass++;
         n_checks++; if (fetch_cnt !== 32'(i)) $display("FAIL run_cnt%0d: got %0d want %0d", i, fetch_cnt, i); else n_pass++;
      end
   endtask

   task automatic test_hold();
      stall  = 1'b1;
      br_req = 1'b1;
      br_pc  = 32'h3100;
      for (int i = 0; i < 3; i++) begin
         tick();
         br_pc = 32'h3400;
         br_req = (i == 0);
         n_checks++; if (pc_f !== 32'h3008) $display("FAIL hold_pc%0d: got %h want 00003008", i, pc_f); else n_pass++;
         n_checks++; if (fetch_cnt !== 32'd2) $display("FAIL hold_cnt%0d: got %0d want 2", i, fetch_cnt); else n_pass++;
      end
      br_req = 1'b0;
      stall  = 1'b0;
      tick();
      n_checks++; if (pc_f !== 32'h3100) $display("FAIL hold_release_pc: got %h want 00003100", pc_f); else n_pass++;
      n_checks++; if (fetch_cnt !== 32'd3) $display("FAIL hold_release_cnt: got %0d want 3", fetch_cnt); else n_pass++;
      tick();
      n_checks++; if (pc_f !== 32'h3104) $display("FAIL hold_seq_pc: got %h want 00003104", pc_f); else n_pass++;
   endtask

   task automatic test_hold_exc();
      stall  = 1'b1;
      br_req = 1'b1;
      br_pc  = 32'h3100;
      tick();
      br_req  = 1'b0;
      exc_req = 1'b1;
      exc_pc  = 32'h3180;
      tick();
      n_checks++; if (pc_f !== 32'h3180) $display("FAIL hold_exc_pc: got %h want 00003180", pc_f); else n_pass++;
      exc_req = 1'b0;
      stall   = 1'b0;
      tick();
      n_checks++; if (pc_f !== 32'h3184) $display("FAIL hold_exc_nopend: got %h want 00003184", pc_f); else n_pass++;
      n_checks++; if (fetch_cnt !== m_cnt) $display("FAIL hold_exc_cnt: got %0d want %0d", fetch_cnt, m_cnt); else n_pass++;
   endtask

   task automatic test_adel();
      logic [31:0] bad [3];
      logic [11:0] ia  [3];
      bad[0] = 32'h3002; ia[0] = 12'hC00;
      bad[1] = 32'h4000; ia[1] = 12'h000;
      bad[2] = 32'h2FFC; ia[2] = 12'hBFF;
      br_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         br_pc = bad[i];
         tick();
         n_checks++; if (exc_code_f !== 5'd4) $display("FAIL adel_exc%0d: got %0d want 4", i, exc_code_f); else n_pass++;
         n_checks++; if (instr_f !== 32'd0) $display("FAIL adel_instr%0d: got %h want 0", i, instr_f); else n_pass++;
         n_checks++; if (valid_f !== 1'b1) $display("FAIL adel_valid%0d: got %b want 1", i, valid_f); else n_pass++;
         n_checks++; if (im_addr !== ia[i]) $display("FAIL adel_addr%0d: got %h want %h", i, im_addr, ia[i]); else n_pass++;
      end
      br_pc = 32'h3FFC;
      tick();
      br_req = 1'b0;
      n_checks++; if (exc_code_f !== 5'd0) $display("FAIL top_word_exc: got %0d want 0", exc_code_f); else n_pass++;
      n_checks++; if (instr_f !== mem[4095]) $display("FAIL top_word_instr: got %h want %h", instr_f, mem[4095]); else n_pass++;
      tick();
      n_checks++; if (exc_code_f !== 5'd4) $display("FAIL past_end_exc: got %0d want 4", exc_code_f); else n_pass++;
   endtask

   task automatic test_br_exc_same();
      br_req  = 1'b1;
      br_pc   = 32'h3200;
      exc_req = 1'b1;
      exc_pc  = 32'h3180;
      tick();
      n_checks++; if (pc_f !== 32'h3180) $display("FAIL br_exc_pc: got %h want 00003180", pc_f); else n_pass++;
      clear_inputs();
      tick();
      n_checks++; if (pc_f !== 32'h3184) $display("FAIL br_exc_next: got %h want 00003184", pc_f); else n_pass++;
   endtask

   task automatic test_reset_hold();
      stall  = 1'b1;
      br_req = 1'b1;
      br_pc  = 32'h3100;
      tick();
      br_req = 1'b0;
      reset  = 1'b1;
      tick();
      n_checks++; if (pc_f !== 32'h3000) $display("FAIL rst_hold_pc: got %h want 00003000", pc_f); else n_pass++;
      n_checks++; if (valid_f !== 1'b0) $display("FAIL rst_hold_valid: got %b want 0", valid_f); else n_pass++;
      n_checks++; if (fetch_cnt !== 32'd0) $display("FAIL rst_hold_cnt: got %0d want 0", fetch_cnt); else n_pass++;
      reset = 1'b0;
      stall = 1'b0;
      tick();
      tick();
      n_checks++; if (pc_f !== 32'h3004) $display("FAIL rst_hold_lost: got %h want 00003004", pc_f); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset   = ($urandom_range(0, 199) == 0);
         stall   = ($urandom_range(0, 2) == 0);
         br_req  = ($urandom_range(0, 3) == 0);
         br_pc   = rand_pc();
         exc_req = ($urandom_range(0, 11) == 0);
         exc_pc  = rand_pc();
         tick();
         n_checks++; if (pc_f !== m_pc) $display("FAIL rnd_pc@%0d: got %h want %h", i, pc_f, m_pc); else n_pass++;
         n_checks++; if (valid_f !== m_booted) $display("FAIL rnd_valid@%0d: got %b want %b", i, valid_f, m_booted); else n_pass++;
         n_checks++; if (instr_f !== m_instr()) $display("FAIL rnd_instr@%0d: got %h want %h", i, instr_f, m_instr()); else n_pass++;
         n_checks++; if (exc_code_f !== m_exc()) $display("FAIL rnd_exc@%0d: got %0d want %0d", i, exc_code_f, m_exc()); else n_pass++;
         n_checks++; if (im_addr !== m_pc[13:2]) $display("FAIL rnd_addr@%0d: got %h want %h", i, im_addr, m_pc[13:2]); else n_pass++;
         n_checks++; if (fetch_cnt !== m_cnt) $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, fetch_cnt, m_cnt); else n_pass++;
      end
      clear_inputs();
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = $urandom();
      m_pc     = 32'h3000;
      m_booted = 1'b0;
      m_cnt    = 32'd0;
      reset    = 1'b1;
      clear_inputs();
      #1;
      test_reset();
      test_free_run();
      test_hold();
      test_hold_exc();
      test_adel();
      test_br_exc_same();
      test_reset_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
